// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM type, PPROT bit positions and width helpers for the
// APB requester/arbiter slice.
package apb_pkg;

  // Requester handshake phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // PPROT attribute bit positions
  localparam int unsigned PPROT_PRIV_BIT   = 0;
  localparam int unsigned PPROT_NONSEC_BIT = 1;
  localparam int unsigned PPROT_INSTR_BIT  = 2;
  localparam int unsigned PPROT_WIDTH      = 3;

  // One strobe bit per data byte
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: command/response bundle toward the local sources plus
// the APB requester signals. master = arbiter side, slave = environment.
interface apb_req_arbiter_if
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  // Local command side
  logic [NUM_REQ-1:0]             cmd_valid;
  logic [NUM_REQ-1:0]             cmd_ready;
  logic [NUM_REQ-1:0]             cmd_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0]  cmd_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]  cmd_wdata;
  logic [NUM_REQ*STRB_WIDTH-1:0]  cmd_strb;
  logic [NUM_REQ*PPROT_WIDTH-1:0] cmd_prot;

  // Local response side
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_rdata;
  logic                           rsp_err;

  // APB requester side
  logic [ADDR_WIDTH-1:0]          paddr;
  logic [DATA_WIDTH-1:0]          pwdata;
  logic [STRB_WIDTH-1:0]          pstrb;
  logic [PPROT_WIDTH-1:0]         pprot;
  logic                           psel;
  logic                           penable;
  logic                           pwrite;
  logic                           pready;
  logic [DATA_WIDTH-1:0]          prdata;
  logic                           pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, pwdata, pstrb, pprot, psel, penable, pwrite
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, pwdata, pstrb, pprot, psel, penable, pwrite
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req starting one past
// last_grant with wrap-around; the pointer register lives in the parent.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Wrapped candidate index; last_grant only ever holds a legal index
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // First requester after last_grant wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = wrap_idx(last_grant, off);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB requester port between NUM_REQ command
// sources, round-robin, one transfer at a time (IDLE -> SETUP -> ACCESS).
// Optional build macro: APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES
// cycles without pready and reports an error response.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               pclk,
  input logic               preset,
  apb_req_arbiter_if.master bus
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);
  localparam int unsigned IDX_W      = $clog2(NUM_REQ);

  // Elaboration-time parameter sanity
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("apb_req_arbiter: NUM_REQ must be 2..8");
  end
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_dw
    $error("apb_req_arbiter: DATA_WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e              state;
  logic [IDX_W-1:0]        last_grant;
  logic [NUM_REQ-1:0]      grant_q;

  logic [NUM_REQ-1:0]      grant_c;
  logic [IDX_W-1:0]        grant_idx_c;
  logic                    accept_c;
  logic                    sel_write_c;
  logic [ADDR_WIDTH-1:0]   sel_addr_c;
  logic [DATA_WIDTH-1:0]   sel_wdata_c;
  logic [STRB_WIDTH-1:0]   sel_strb_c;
  logic [PPROT_WIDTH-1:0]  sel_prot_c;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  rr_arbiter #(
    .NUM_REQ    (NUM_REQ)
  ) u_rr_arbiter (
    .req        (bus.cmd_valid),
    .last_grant (last_grant),
    .grant      (grant_c)
  );

  // Accept only in IDLE; ready is the one-hot grant in that same cycle
  assign accept_c      = (state == IDLE) && (|bus.cmd_valid);
  assign bus.cmd_ready = accept_c ? grant_c : '0;

  // One-hot mux of the granted source's command fields
  always_comb begin
    grant_idx_c = '0;
    sel_write_c = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_strb_c  = '0;
    sel_prot_c  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        grant_idx_c = IDX_W'(i);
        sel_write_c = bus.cmd_write[i];
        sel_addr_c  = bus.cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_c = bus.cmd_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb_c  = bus.cmd_strb[i*STRB_WIDTH +: STRB_WIDTH];
        sel_prot_c[PPROT_PRIV_BIT]   = bus.cmd_prot[i*PPROT_WIDTH + PPROT_PRIV_BIT];
        sel_prot_c[PPROT_NONSEC_BIT] = bus.cmd_prot[i*PPROT_WIDTH + PPROT_NONSEC_BIT];
        sel_prot_c[PPROT_INSTR_BIT]  = bus.cmd_prot[i*PPROT_WIDTH + PPROT_INSTR_BIT];
      end
    end
  end

  // Requester FSM with registered APB and response outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      grant_q       <= '0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.pstrb     <= '0;
      bus.pprot     <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            bus.paddr   <= sel_addr_c;
            bus.pwdata  <= sel_wdata_c;
            bus.pstrb   <= sel_write_c ? sel_strb_c : '0;
            bus.pprot   <= sel_prot_c;
            bus.pwrite  <= sel_write_c;
            bus.psel    <= 1'b1;
            bus.penable <= 1'b0;
            last_grant  <= grant_idx_c;
            grant_q     <= grant_c;
            state       <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= grant_q;
            bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
            bus.rsp_err   <= bus.pslverr;
            state         <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Completer never answered: abort with an error response
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= grant_q;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt      <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed vectors with a queue-based scoreboard. The
// stimulus pushes expected grants/APB phases/responses; a driver, an APB
// completer model and a response monitor pop and compare independently.
module tb_apb_req_arbiter;
  import apb_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = 4;
  localparam int unsigned TO      = 8;

  logic pclk = 1'b0;
  logic preset;
  int   cyc  = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  typedef struct {
    int          src;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } txn_t;

  txn_t src_q[NUM_REQ][$];
  txn_t apb_q[$];
  txn_t rsp_q[$];
  int   grant_q[$];
  int   acc_q[$];
  int   last_acc = 0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event or expired bound (cycle %0d)", name, cyc);
  endtask

  task automatic add(input int src, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [2:0] prot, input int waits, input logic [31:0] rd,
                     input logic err, input logic [31:0] exp_rdata,
                     input logic exp_err, input int exp_lat);
    txn_t t;
    t.src = src; t.write = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
    t.prot = prot; t.waits = waits; t.rd = rd; t.err = err;
    t.exp_rdata = exp_rdata; t.exp_err = exp_err; t.exp_lat = exp_lat;
    src_q[src].push_back(t);
    grant_q.push_back(src);
    apb_q.push_back(t);
    rsp_q.push_back(t);
  endtask

  task automatic drain(input string phase);
    int n = 0;
    while ((rsp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            bus.cmd_valid != '0) && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 300) fail({"drain_", phase});
    repeat (2) @(negedge pclk);
  endtask

  // Command driver: holds cmd_valid until accepted, then loads the next one
  initial begin : driver
    logic [NUM_REQ-1:0] acc_prev;
    txn_t t;
    int   g;
    acc_prev      = '0;
    bus.cmd_valid = '0;
    bus.cmd_write = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    forever begin
      @(negedge pclk);
      for (int s = 0; s < NUM_REQ; s++) begin
        if (acc_prev[s]) bus.cmd_valid[s] = 1'b0;
        if (!bus.cmd_valid[s] && src_q[s].size() > 0) begin
          t = src_q[s].pop_front();
          bus.cmd_write[s]        = t.write;
          bus.cmd_addr[s*32 +: 32] = t.addr;
          bus.cmd_wdata[s*32 +: 32] = t.wdata;
          bus.cmd_strb[s*4 +: 4]   = t.strb;
          bus.cmd_prot[s*3 +: 3]   = t.prot;
          bus.cmd_valid[s]        = 1'b1;
        end
      end
      #1;
      acc_prev = '0;
      if (!preset && bus.cmd_ready != '0) begin
        acc_prev = bus.cmd_ready;
        if (grant_q.size() == 0) begin
          fail("unexpected_grant");
        end else begin
          g = grant_q.pop_front();
          chk("cmd_ready", 32'(bus.cmd_ready), 32'(1 << g));
        end
        acc_q.push_back(cyc);
        last_acc = cyc;
      end
    end
  end

  // APB completer model: checks SETUP/ACCESS phases, inserts wait states
  initial begin : completer
    txn_t cur;
    int   wcnt;
    int   setup_cyc;
    logic first;
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;
    wcnt = 0; setup_cyc = 0; first = 1'b0;
    forever begin
      @(negedge pclk);
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0BAD_0BAD;
      if (!preset && bus.psel && !bus.penable) begin
        if (apb_q.size() == 0) begin
          fail("unexpected_setup");
        end else begin
          cur = apb_q.pop_front();
          chk("setup_latency", 32'(cyc - last_acc), 32'd1);
          chk("setup_paddr", bus.paddr, cur.addr);
          chk("setup_pwrite", 32'(bus.pwrite), 32'(cur.write));
          chk("setup_pstrb", 32'(bus.pstrb), cur.write ? 32'(cur.strb) : 32'd0);
          chk("setup_pprot", 32'(bus.pprot), 32'(cur.prot));
          if (cur.write) chk("setup_pwdata", bus.pwdata, cur.wdata);
        end
        setup_cyc = cyc;
        wcnt      = 0;
        first     = 1'b1;
      end else if (!preset && bus.psel && bus.penable) begin
        if (first) chk("penable_latency", 32'(cyc - setup_cyc), 32'd1);
        first = 1'b0;
        chk("access_paddr", bus.paddr, cur.addr);
        chk("access_pstrb", 32'(bus.pstrb), cur.write ? 32'(cur.strb) : 32'd0);
        if (wcnt >= cur.waits) begin
          bus.pready  = 1'b1;
          bus.pslverr = cur.err;
          bus.prdata  = cur.write ? 32'hBAD0_F00D : cur.rd;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever rsp_valid is seen
  initial begin : monitor
    txn_t t;
    int   a;
    forever begin
      @(negedge pclk);
      if (!preset && bus.rsp_valid != '0) begin
        if (rsp_q.size() == 0 || acc_q.size() == 0) begin
          fail("unexpected_rsp_valid");
        end else begin
          t = rsp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << t.src));
          chk("rsp_rdata", bus.rsp_rdata, t.exp_rdata);
          chk("rsp_err", 32'(bus.rsp_err), 32'(t.exp_err));
          chk("rsp_latency", 32'(cyc - a), 32'(t.exp_lat));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin : stim
    int n;
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_paddr", bus.paddr, 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_pstrb", 32'(bus.pstrb), 32'd0);
    chk("rst_pprot", 32'(bus.pprot), 32'd0);
    preset = 1'b0;
    @(negedge pclk);

    // Single write from source 0, zero wait states
    add(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b000, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3);
    drain("write0");

    // Read from source 1 with two wait states
    add(1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b010, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 5);
    drain("read1");

    // Both sources busy: grants alternate 0,1,0,1,0,1
    add(0, 1'b1, 32'h100, 32'h1111_0000, 4'h3, 3'b001, 0, 32'h0,         1'b0, 32'h0,         1'b0, 3);
    add(1, 1'b0, 32'h104, 32'h0,         4'hF, 3'b010, 0, 32'h2222_0001, 1'b0, 32'h2222_0001, 1'b0, 3);
    add(0, 1'b0, 32'h108, 32'h0,         4'hF, 3'b000, 0, 32'h3333_0002, 1'b0, 32'h3333_0002, 1'b0, 3);
    add(1, 1'b1, 32'h10C, 32'h4444_0003, 4'hC, 3'b100, 0, 32'h0,         1'b0, 32'h0,         1'b0, 3);
    add(0, 1'b1, 32'h110, 32'h5555_0004, 4'hF, 3'b011, 0, 32'h0,         1'b0, 32'h0,         1'b0, 3);
    add(1, 1'b0, 32'h114, 32'h0,         4'h0, 3'b111, 0, 32'h6666_0005, 1'b0, 32'h6666_0005, 1'b0, 3);
    drain("round_robin");

    // Error on a read, clean write right after
    add(0, 1'b0, 32'h200, 32'h0,         4'hF, 3'b000, 1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 4);
    add(1, 1'b1, 32'h204, 32'h0BAD_CAFE, 4'hF, 3'b000, 0, 32'h0,         1'b0, 32'h0,         1'b0, 3);
    drain("slverr");

    // Reset during ACCESS: transfer dropped, pointer back to source 1
    add(0, 1'b0, 32'h300, 32'h0, 4'hF, 3'b000, 5, 32'h7777_7777, 1'b0, 32'h7777_7777, 1'b0, 8);
    n = 0;
    while (!(bus.psel && bus.penable) && n < 20) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 20) fail("reach_access");
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    chk("abort_psel", 32'(bus.psel), 32'd0);
    chk("abort_penable", 32'(bus.penable), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_paddr", bus.paddr, 32'd0);
    rsp_q.delete();
    acc_q.delete();
    apb_q.delete();
    grant_q.delete();
    repeat (2) @(negedge pclk);
    add(0, 1'b1, 32'h400, 32'hCAFE_0000, 4'hF, 3'b000, 0, 32'h0,         1'b0, 32'h0,         1'b0, 3);
    add(1, 1'b0, 32'h404, 32'h0,         4'hF, 3'b000, 0, 32'h8888_0001, 1'b0, 32'h8888_0001, 1'b0, 3);
    drain("post_reset");

`ifdef APB_TIMEOUT_EN
    // Completer never ready: abort after TO ACCESS cycles with an error
    add(1, 1'b0, 32'h500, 32'h0, 4'hF, 3'b000, 100, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 2 + TO);
    drain("timeout");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
